fetch_ctrl: RTL

Sequencing controller for the instruction-fetch unit. It drives the program counter's stall/compressed/je/ja inputs, issues single-outstanding requests to instruction memory, and holds each fetched instruction for decode behind a valid/ready handshake. It sits in the IFU beside the program counter, between imem and decode.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 33 +++
 rtl/fetch_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared IFU definitions: fetch sequencer states, instruction width and the
// compressed-encoding test used when advancing the PC.
package ifu_pkg;

    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic is_compressed(input logic [31:0] i);
        return (i[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of PC-control, imem and decode handshake signals around fetch_ctrl.
// master is the controller side, slave is the surrounding PC/imem/decode side.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] curr_pc;
    logic            pc_stall;
    logic            pc_compressed;
    logic            pc_je;
    logic [XLEN-1:0] pc_ja;
    logic            je;
    logic [XLEN-1:0] ja;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  curr_pc, je, ja, imem_ack, imem_rdata, instr_ready,
        output pc_stall, pc_compressed, pc_je, pc_ja, imem_req, imem_addr,
               instr_valid, instr, instr_pc
    );

    modport slave (
        output curr_pc, je, ja, imem_ack, imem_rdata, instr_ready,
        input  pc_stall, pc_compressed, pc_je, pc_ja, imem_req, imem_addr,
               instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steers the PC, issues single-outstanding imem
// requests and holds each fetched instruction for decode.
module fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    fetch_state_t    state_r, state_s;
    logic [XLEN-1:0] addr_r;
    logic [ILEN-1:0] instr_r;
    logic [XLEN-1:0] instr_pc_r;
    logic [XLEN-1:0] ja_even_s;

    assign ja_even_s = {bus.ja[XLEN-1:1], 1'b0};

    // State and captured-instruction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= BOOT;
            addr_r     <= {XLEN{1'b0}};
            instr_r    <= {ILEN{1'b0}};
            instr_pc_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == REQ) begin
                addr_r <= bus.curr_pc;
                if (bus.imem_ack && !bus.je) begin
                    instr_r    <= bus.imem_rdata;
                    instr_pc_r <= bus.curr_pc;
                end
            end
        end
    end

    // Next-state and output decode; a redirect always loads the PC without stalling.
    always_comb begin
        state_s           = state_r;
        bus.pc_stall      = 1'b1;
        bus.pc_compressed = 1'b0;
        bus.pc_je         = 1'b0;
        bus.pc_ja         = ja_even_s;
        bus.imem_req      = 1'b0;
        bus.imem_addr     = {XLEN{1'b0}};
        bus.instr_valid   = 1'b0;
        bus.instr         = {ILEN{1'b0}};
        bus.instr_pc      = {XLEN{1'b0}};
        case (state_r)
            BOOT: begin
                bus.pc_je    = 1'b1;
                bus.pc_stall = 1'b0;
                bus.pc_ja    = (bus.je && !rst) ? ja_even_s : RESET_VECTOR;
                state_s      = REQ;
            end
            REQ: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = bus.curr_pc;
                if (bus.je) begin
                    bus.pc_je    = 1'b1;
                    bus.pc_stall = 1'b0;
                    state_s      = bus.imem_ack ? REQ : FLUSH;
                end else if (bus.imem_ack) begin
                    state_s = HOLD;
                end else begin
                    state_s = REQ;
                end
            end
            FLUSH: begin
                // The abandoned request stays on the bus until imem answers it.
                bus.imem_req  = 1'b1;
                bus.imem_addr = addr_r;
                if (bus.je) begin
                    bus.pc_je    = 1'b1;
                    bus.pc_stall = 1'b0;
                end else begin
                    bus.pc_je = 1'b0;
                end
                state_s = bus.imem_ack ? REQ : FLUSH;
            end
            HOLD: begin
                bus.instr_valid = 1'b1;
                bus.instr       = instr_r;
                bus.instr_pc    = instr_pc_r;
                if (bus.je) begin
                    bus.pc_je    = 1'b1;
                    bus.pc_stall = 1'b0;
                    state_s      = REQ;
                end else if (bus.instr_ready) begin
                    bus.pc_stall      = 1'b0;
                    bus.pc_compressed = is_compressed(instr_r);
                    state_s           = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

endmodule
